mac_array_seq: RTL and testbench

- Instruction sequencer for a row x col grid of mac_tile instances.
- Drives the 3-bit inst_w of the west-edge tile in every row, skewed one cycle per row to match systolic propagation.
- Runs a complete weight-stationary (WS) or output-stationary (OS) job: weight load / execute / psum move / drain.
- Gates progress on an upstream data-valid handshake.

---
 rtl/mac_array_seq.sv | 177 +++++++++++++++++
 tb/tb_mac_array_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// mac_array_seq: drives skewed inst_w lanes for a row x col mac_tile grid (WS/OS load, exec, move, drain).
// Latency: lane0 carries the FSM instruction one cycle after it is chosen; lane r trails lane0 by r cycles.
// Backpressure: in_valid low stalls LOAD/EXEC (idle code, count holds); MOVE/DRAIN/DONE run freely.
module mac_array_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [len_bw-1:0]   k_len,
    input  logic                in_valid,
    output logic                in_rd,
    output logic [3*row-1:0]    inst_row,
    output logic                busy,
    output logic                done
);

    localparam int CW = len_bw + 1;
    localparam logic [CW-1:0] LOAD_BEATS = CW'(col);
    localparam logic [CW-1:0] MOVE_CYC   = CW'(2 * row);
    localparam logic [CW-1:0] DRAIN_CYC  = CW'(row + col - 1);

    localparam logic [2:0] I_WS_LOAD = 3'b101;
    localparam logic [2:0] I_WS_EXEC = 3'b110;
    localparam logic [2:0] I_OS_EXEC = 3'b010;
    localparam logic [2:0] I_OS_MOVE = 3'b001;
    localparam logic [2:0] I_OFF     = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_MOVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [len_bw-1:0]   k_len_q, k_len_d;
    logic [2:0]          lane_q [row];
    logic [2:0]          lane_d [row];

    logic [CW-1:0]       cnt_inc;
    logic [CW-1:0]       k_len_ext;
    logic [2:0]          idle_code;
    logic [2:0]          fsm_inst;

    // Counter is one bit wider than k_len so a full-scale k_len never wraps.
    assign cnt_inc   = cnt_q + 1'b1;
    assign k_len_ext = {1'b0, k_len_q};
    assign idle_code = {mode_q, 2'b00};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        k_len_d  = k_len_q;
        fsm_inst = idle_code;
        in_rd    = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                fsm_inst = I_OFF;
                if (start) begin
                    mode_d  = mode;
                    k_len_d = k_len;
                    cnt_d   = '0;
                    if (mode) begin
                        state_d = S_LOAD;
                    end else if (k_len == '0) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_LOAD: begin
                if (in_valid) begin
                    fsm_inst = I_WS_LOAD;
                    in_rd    = 1'b1;
                    if (cnt_inc == LOAD_BEATS) begin
                        cnt_d   = '0;
                        state_d = (k_len_q == '0) ? S_DRAIN : S_EXEC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_EXEC: begin
                if (in_valid) begin
                    fsm_inst = mode_q ? I_WS_EXEC : I_OS_EXEC;
                    in_rd    = 1'b1;
                    if (cnt_inc == k_len_ext) begin
                        cnt_d   = '0;
                        state_d = mode_q ? S_DRAIN : S_MOVE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            // Psum hops take two cycles each, so the move phase is 2*row long.
            S_MOVE: begin
                fsm_inst = I_OS_MOVE;
                if (cnt_inc == MOVE_CYC) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DRAIN: begin
                if (cnt_inc == DRAIN_CYC) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lane_d[0] = fsm_inst;
        for (int r = 1; r < row; r++) begin
            lane_d[r] = lane_q[r-1];
        end
    end

    always_comb begin
        for (int r = 0; r < row; r++) begin
            inst_row[3*r +: 3] = lane_q[r];
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            k_len_q <= '0;
            for (int r = 0; r < row; r++) begin
                lane_q[r] <= 3'b000;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            k_len_q <= k_len_d;
            for (int r = 0; r < row; r++) begin
                lane_q[r] <= lane_d[r];
            end
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq (row=4, col=4): table of job vectors, reset/start corner sequences, random jobs vs phase model.
module tb_mac_array_seq;

    localparam int ROW    = 4;
    localparam int COL    = 4;
    localparam int LEN_BW = 8;
    localparam int MAXC   = 1024;

    logic                clk;
    logic                reset;
    logic                start;
    logic                mode;
    logic [LEN_BW-1:0]   k_len;
    logic                in_valid;
    logic                in_rd;
    logic [3*ROW-1:0]    inst_row;
    logic                busy;
    logic                done;

    mac_array_seq #(.row(ROW), .col(COL), .len_bw(LEN_BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_rd    (in_rd),
        .inst_row (inst_row),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        bit         rd;
        bit         dn;
    } beat_t;

    typedef struct {
        bit    md;
        int    k;
        int    stall_at;
        int    stall_len;
        bit    dup;
        int    tail;
        int    e_rd;
        int    e_busy;
        int    e_done;
        string nm;
    } vec_t;

    int          n_chk;
    int          n_pass;
    int          t;
    bit          vpat [MAXC];
    beat_t       exp_q [$];
    logic [2:0]  fsm_log [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        #1;
    endtask

    function automatic logic [2:0] code_at(input int tt);
        return fsm_log.exists(tt) ? fsm_log[tt] : 3'b000;
    endfunction

    function automatic logic [3*ROW-1:0] exp_lanes(input int tt);
        logic [3*ROW-1:0] v;
        v = '0;
        for (int r = 0; r < ROW; r++) begin
            v[3*r +: 3] = code_at(tt - 1 - r);
        end
        return v;
    endfunction

    // Job reference: phases consume valid beats (load, exec) or fixed cycle counts (move, drain, done).
    task automatic build_exp(input bit md, input int k);
        int c;
        int got;
        logic [2:0] idle;
        beat_t b;
        exp_q.delete();
        idle = md ? 3'b100 : 3'b000;
        c = 0;
        if (md) begin
            got = 0;
            while (got < COL) begin
                b.code = vpat[c] ? 3'b101 : idle;
                b.rd   = vpat[c];
                b.dn   = 1'b0;
                exp_q.push_back(b);
                got += vpat[c] ? 1 : 0;
                c++;
            end
        end
        got = 0;
        while (got < k) begin
            b.code = vpat[c] ? (md ? 3'b110 : 3'b010) : idle;
            b.rd   = vpat[c];
            b.dn   = 1'b0;
            exp_q.push_back(b);
            got += vpat[c] ? 1 : 0;
            c++;
        end
        if (!md) begin
            for (int i = 0; i < 2*ROW; i++) begin
                b.code = 3'b001; b.rd = 1'b0; b.dn = 1'b0;
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < ROW+COL-1; i++) begin
            b.code = idle; b.rd = 1'b0; b.dn = 1'b0;
            exp_q.push_back(b);
        end
        b.code = idle; b.rd = 1'b0; b.dn = 1'b1;
        exp_q.push_back(b);
    endtask

    task automatic run_job(input bit md, input int k, input bit dup, input int tail,
                           input bit use_tbl, input int e_rd, input int e_busy,
                           input int e_done, input string nm);
        int n;
        int n_rd;
        int n_busy;
        int done_at;
        int m_rd;
        build_exp(md, k);
        n = exp_q.size();
        m_rd = 0;
        foreach (exp_q[i]) m_rd += exp_q[i].rd ? 1 : 0;

        tick();
        start    = 1'b1;
        mode     = md;
        k_len    = LEN_BW'(k);
        in_valid = 1'($urandom);
        @(negedge clk);
        chk({nm, " start"}, 64'({busy, done, in_rd, inst_row}), 64'({3'b000, exp_lanes(t)}));
        for (int c = 0; c < n; c++) fsm_log[t + 1 + c] = exp_q[c].code;

        n_rd = 0; n_busy = 0; done_at = -1;
        for (int c = 0; c < n; c++) begin
            tick();
            start    = dup && (c == 2 || c == n - 1);
            mode     = 1'($urandom);
            k_len    = LEN_BW'($urandom);
            in_valid = vpat[c];
            @(negedge clk);
            chk({nm, " cyc"}, 64'({busy, done, in_rd, inst_row}),
                64'({1'b1, exp_q[c].dn, exp_q[c].rd, exp_lanes(t)}));
            n_rd   += in_rd ? 1 : 0;
            n_busy += busy ? 1 : 0;
            if (done && done_at < 0) done_at = c;
        end
        for (int c = 0; c < tail; c++) begin
            tick();
            start    = 1'b0;
            in_valid = 1'($urandom);
            @(negedge clk);
            chk({nm, " tail"}, 64'({busy, done, in_rd, inst_row}), 64'({3'b000, exp_lanes(t)}));
            n_busy += busy ? 1 : 0;
        end
        start = 1'b0;
        if (use_tbl) begin
            chk({nm, " rd_count"},  64'(n_rd),    64'(e_rd));
            chk({nm, " busy_cycles"}, 64'(n_busy), 64'(e_busy));
            chk({nm, " done_cycle"}, 64'(done_at), 64'(e_done));
        end else begin
            chk({nm, " rd_count"},   64'(n_rd),    64'(m_rd));
            chk({nm, " done_cycle"}, 64'(done_at), 64'(n - 1));
        end
    endtask

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; t = 0;
        // done_cycle counts job cycles from 0 = first cycle after the accepting edge.
        tbl[0] = '{1'b1,   3, -1, 0, 1'b0, 5,   7,  15,  14, "ws_k3"};
        tbl[1] = '{1'b0,   5, -1, 0, 1'b0, 5,   5,  21,  20, "os_k5"};
        tbl[2] = '{1'b1,   4,  6, 2, 1'b0, 5,   8,  18,  17, "ws_k4_stall"};
        tbl[3] = '{1'b0,   0, -1, 0, 1'b0, 5,   0,  16,  15, "os_k0"};
        tbl[4] = '{1'b1,   0, -1, 0, 1'b0, 5,   4,  12,  11, "ws_k0"};
        tbl[5] = '{1'b1, 255, -1, 0, 1'b0, 5, 259, 267, 266, "ws_kmax"};
        tbl[6] = '{1'b0, 255, -1, 0, 1'b0, 5, 255, 271, 270, "os_kmax"};
        tbl[7] = '{1'b1,   2, -1, 0, 1'b1, 0,   6,  14,  13, "ws_dup_start"};
        tbl[8] = '{1'b0,   1, -1, 0, 1'b0, 6,   1,  17,  16, "os_after_done"};

        reset = 1'b0; start = 1'b0; mode = 1'b0; k_len = '0; in_valid = 1'b1;
        #2;
        chk("reset_state", 64'({busy, done, in_rd, inst_row}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            for (int c = 0; c < MAXC; c++) begin
                vpat[c] = !(c >= tbl[i].stall_at && c < tbl[i].stall_at + tbl[i].stall_len);
            end
            run_job(tbl[i].md, tbl[i].k, tbl[i].dup, tbl[i].tail, 1'b1,
                    tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_done, tbl[i].nm);
        end

        // Asynchronous reset in the middle of an OS execute phase.
        tick();
        start = 1'b1; mode = 1'b0; k_len = LEN_BW'(10); in_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy_rd", 64'({busy, in_rd}), 64'(2'b11));
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy, done, in_rd, inst_row}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        fsm_log.delete();
        for (int c = 0; c < MAXC; c++) vpat[c] = 1'b1;
        run_job(1'b1, 3, 1'b0, 5, 1'b1, 7, 15, 14, "ws_after_reset");

        for (int j = 0; j < 30; j++) begin
            bit md;
            int k;
            md = 1'($urandom);
            k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            for (int c = 0; c < MAXC; c++) begin
                vpat[c] = (c >= 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
            end
            run_job(md, k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)),
                    1'b0, 0, 0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
